// File: rtl/serial_full_adder.sv
// serial_full_adder: bit-serial adder built around one full-adder cell and a
// registered carry. Adds WIDTH-bit a + b + cin, LSB first, one bit per clock.
// It runs a start/busy/done handshake, and the result is held until the next
// completion.
// Optional feature: define SERIAL_FULL_ADDER_OVF_EN to add the registered
// signed-overflow output ovf.
module serial_full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic             s_d;
    logic             carry_d;
    logic [WIDTH-1:0] sa_d;
    logic [WIDTH-1:0] sb_d;
    logic [WIDTH-1:0] res_d;

    // Full-adder cell on the current LSBs, plus the operand shift.
    always_comb begin
        s_d     = sa_q[0] ^ sb_q[0] ^ carry_q;
        carry_d = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
    end

    // The result register fills from the MSB. A 1-bit result has no upper
    // slice to shift, so it takes the new bit directly.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_d = s_d;
        end else begin : g_res_wn
            assign res_d = {s_d, res_q[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and datapath registers. Results commit only on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa_q    <= sa_d;
                    sb_q    <= sb_d;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
`ifdef SERIAL_FULL_ADDER_OVF_EN
                        // carry_q is still the carry into the MSB on this edge
                        ovf_q   <= carry_q ^ carry_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
// Scoreboard bench for serial_full_adder. It drives a WIDTH=8 instance and a
// WIDTH=1 instance. Expected {ovf,cout,sum} values are hand-computed.
module tb_serial_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    serial_full_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_FULL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_full_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_FULL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Expected entries are {ovf, cout, sum}.
    logic [9:0] q8[$];
    logic [2:0] q1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor for the 8-bit instance. It checks the result on each done and
    // checks that the result is held between dones.
    logic [9:0] e8;
    logic [8:0] held8 = '0;
    always @(negedge clk) begin
        if (rst) begin
            held8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done8_unexpected actual=%0h required=no_done", {cout8, sum8});
            end else begin
                e8 = q8.pop_front();
                chk("sum8", sum8, e8[7:0]);
                chk("cout8", cout8, e8[8]);
`ifdef SERIAL_FULL_ADDER_OVF_EN
                chk("ovf8", ovf8, e8[9]);
`endif
            end
            held8 = {cout8, sum8};
        end else begin
            chk("hold8", {cout8, sum8}, held8);
        end
    end

    // Monitor for the 1-bit instance.
    logic [2:0] e1;
    logic [1:0] held1 = '0;
    always @(negedge clk) begin
        if (rst) begin
            held1 = '0;
        end else if (done1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done1_unexpected actual=%0h required=no_done", {cout1, sum1});
            end else begin
                e1 = q1.pop_front();
                chk("sum1", sum1, e1[0]);
                chk("cout1", cout1, e1[1]);
`ifdef SERIAL_FULL_ADDER_OVF_EN
                chk("ovf1", ovf1, e1[2]);
`endif
            end
            held1 = {cout1, sum1};
        end else begin
            chk("hold1", {cout1, sum1}, held1);
        end
    end

    // Counts negedges after the start edge until done, with a bound.
    task automatic wait_done8(input int req_cyc, input int req_busy);
        int cyc = 0;
        int bc  = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy8) bc++;
            if (done8) seen = 1'b1;
        end
        chk("done8_seen", seen, 1);
        chk("done8_cycle", cyc, req_cyc);
        chk("busy8_cycles", bc, req_busy);
    endtask

    task automatic wait_done1(input int req_cyc, input int req_busy);
        int cyc = 0;
        int bc  = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy1) bc++;
            if (done1) seen = 1'b1;
        end
        chk("done1_seen", seen, 1);
        chk("done1_cycle", cyc, req_cyc);
        chk("busy1_cycles", bc, req_busy);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [9:0] req);
        @(negedge clk);
        start8 = 1'b1;
        a8     = ta;
        b8     = tb;
        cin8   = tc;
        q8.push_back(req);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8(9, 8);
    endtask

    task automatic op1(input logic [2:0] abc, input logic [2:0] req);
        @(negedge clk);
        start1 = 1'b1;
        a1     = abc[2];
        b1     = abc[1];
        cin1   = abc[0];
        q1.push_back(req);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done1(2, 1);
    endtask

    // Hand-computed full-adder table for inputs {a,b,cin}.
    logic [1:0] tt_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic       tt_ov [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;

        #7;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_sum1", {cout1, sum1}, 0);
`ifdef SERIAL_FULL_ADDER_OVF_EN
        chk("rst_ovf8", ovf8, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Wrap-around, and the two signed-overflow cases.
        op8(8'hFF, 8'h01, 1'b0, {1'b0, 9'h100});
        op8(8'h7F, 8'h01, 1'b0, {1'b1, 9'h080});
        op8(8'h80, 8'h80, 1'b0, {1'b1, 9'h100});

        // start is held high while a/b change during SHIFT and DONE. The
        // second op is accepted only after the return to IDLE.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h12;
        b8     = 8'h34;
        cin8   = 1'b1;
        q8.push_back({1'b0, 9'h047});
        q8.push_back({1'b0, 9'h0FF});
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 9) begin
                a8   = 8'(i * 37 + 5);
                b8   = ~a8 ^ 8'h3C;
                cin8 = i[0];
            end else begin
                a8   = 8'h0F;
                b8   = 8'hF0;
                cin8 = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8(9, 8);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'hAA;
        b8     = 8'h55;
        cin8   = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", busy8, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_cout", cout8, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op8(8'h01, 8'h02, 1'b0, {1'b0, 9'h003});

        // Back-to-back: start held high across three operations.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h55;
        b8     = 8'h66;
        cin8   = 1'b0;
        q8.push_back({1'b1, 9'h0BB});
        for (int op = 0; op < 3; op++) begin
            @(posedge clk);
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                chk("b2b_busy", busy8, (j < 8) ? 1 : 0);
                chk("b2b_done", done8, (j == 8) ? 1 : 0);
                if (j == 9) begin
                    if (op == 0) begin
                        a8   = 8'hC8;
                        b8   = 8'h64;
                        cin8 = 1'b1;
                        q8.push_back({1'b0, 9'h12D});
                    end else if (op == 1) begin
                        a8   = 8'h01;
                        b8   = 8'hFE;
                        cin8 = 1'b1;
                        q8.push_back({1'b0, 9'h100});
                    end else begin
                        start8 = 1'b0;
                    end
                end
            end
        end
        repeat (12) @(negedge clk);
        chk("b2b_idle_busy", busy8, 0);

        // WIDTH=1: the full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            op1(3'(i), {tt_ov[i], tt_cs[i]});
        end

        repeat (4) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
